// File: rtl/hazard_scoreboard.sv
// Hazard unit for the five-stage MIPS pipeline: shift-register writer scoreboard, D-stage stall, forward selects.
// Optional multiply/divide busy tracking is compiled in with `define HAZ_MDU_EN.

module hazard_src_check #(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 5,
  parameter int T_W        = 3,
  parameter int FW         = 2
) (
  input  logic [NUM_STAGES:1]            vld,
  input  logic [NUM_STAGES:1][REG_W-1:0] a3,
  input  logic [NUM_STAGES:1][T_W-1:0]   tnew,
  input  logic [REG_W-1:0]               src,
  input  logic [T_W-1:0]                 tuse,
  output logic                           stall_o,
  output logic [FW-1:0]                  fwd_o
);
  logic           hit;
  logic [T_W-1:0] tnew_hit;
  logic [FW-1:0]  k_hit;

  // Scan oldest to youngest so the youngest match overwrites and shadows older ones.
  always_comb begin
    hit      = 1'b0;
    tnew_hit = '0;
    k_hit    = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (vld[k] && (a3[k] == src) && (src != '0)) begin
        hit      = 1'b1;
        tnew_hit = tnew[k];
        k_hit    = FW'(k);
      end
    end
    stall_o = hit && (tnew_hit > tuse);
    fwd_o   = (hit && (tnew_hit == '0)) ? k_hit : '0;
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_STAGES  = 3,
  parameter int REG_W       = 5,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int FW         = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [T_W-1:0]   D_Tuse_rs,
  input  logic [T_W-1:0]   D_Tuse_rt,
  input  logic             D_RegWrite,
  input  logic [REG_W-1:0] D_A3,
  input  logic [T_W-1:0]   D_Tnew,
`ifdef HAZ_MDU_EN
  input  logic             D_is_md,
  input  logic             D_is_mul,
  input  logic             D_uses_md,
  output logic             md_busy,
`endif
  output logic             stall,
  output logic [FW-1:0]    fwd_rs,
  output logic [FW-1:0]    fwd_rt
);
  logic [NUM_STAGES:1]            vld_q, vld_d;
  logic [NUM_STAGES:1][REG_W-1:0] a3_q, a3_d;
  logic [NUM_STAGES:1][T_W-1:0]   tnew_q, tnew_d;
  logic                           stall_rs, stall_rt, md_stall;

  hazard_src_check #(.NUM_STAGES(NUM_STAGES), .REG_W(REG_W), .T_W(T_W), .FW(FW)) u_rs (
    .vld(vld_q), .a3(a3_q), .tnew(tnew_q), .src(D_rs), .tuse(D_Tuse_rs),
    .stall_o(stall_rs), .fwd_o(fwd_rs)
  );

  hazard_src_check #(.NUM_STAGES(NUM_STAGES), .REG_W(REG_W), .T_W(T_W), .FW(FW)) u_rt (
    .vld(vld_q), .a3(a3_q), .tnew(tnew_q), .src(D_rt), .tuse(D_Tuse_rt),
    .stall_o(stall_rt), .fwd_o(fwd_rt)
  );

  assign stall = D_valid & (stall_rs | stall_rt | md_stall);

  // Entry 1 gets a bubble on stall; E and beyond always advance.
  always_comb begin
    vld_d     = '0;
    a3_d      = '0;
    tnew_d    = '0;
    vld_d[1]  = D_valid & D_RegWrite & (D_A3 != '0) & ~stall;
    a3_d[1]   = D_A3;
    tnew_d[1] = D_Tnew;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      vld_d[k]  = vld_q[k-1];
      a3_d[k]   = a3_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - T_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      a3_q   <= '0;
      tnew_q <= '0;
    end else begin
      vld_q  <= vld_d;
      a3_q   <= a3_d;
      tnew_q <= tnew_d;
    end
  end

`ifdef HAZ_MDU_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign md_busy  = (cnt_q != '0);
  assign md_stall = (D_uses_md | D_is_md) & md_busy;

  // A new mult/div can only issue once the unit is idle, so load never races the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (D_valid && !stall && D_is_md)
      cnt_d = D_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_md_cfg;
  assign unused_md_cfg = ^{MULT_CYCLES[0], DIV_CYCLES[0]};
  assign md_stall      = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of hazard_scoreboard stall/forward decisions (default parameters).
module tb_hazard_scoreboard;
  logic       clk, reset;
  logic       D_valid, D_RegWrite;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [2:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
`ifdef HAZ_MDU_EN
  logic       D_is_md, D_is_mul, D_uses_md, md_busy;
`endif
  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_RegWrite(D_RegWrite),
    .D_A3(D_A3), .D_Tnew(D_Tnew),
`ifdef HAZ_MDU_EN
    .D_is_md(D_is_md), .D_is_mul(D_is_mul), .D_uses_md(D_uses_md), .md_busy(md_busy),
`endif
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] urs, input logic [2:0] urt,
                       input logic rw, input logic [4:0] a3, input logic [2:0] tn);
    D_valid = v; D_rs = rs; D_rt = rt; D_Tuse_rs = urs; D_Tuse_rt = urt;
    D_RegWrite = rw; D_A3 = a3; D_Tnew = tn;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic s, input logic [1:0] fr, input logic [1:0] ft);
    checks++;
    assert ({stall, fwd_rs, fwd_rt} === {s, fr, ft})
    else begin
      errors++;
      $error("FAIL %s: got stall=%b fwd_rs=%0d fwd_rt=%0d, want stall=%b fwd_rs=%0d fwd_rt=%0d",
             tag, stall, fwd_rs, fwd_rt, s, fr, ft);
    end
  endtask

`ifdef HAZ_MDU_EN
  task automatic chk_md(input string tag, input logic s, input logic b);
    checks++;
    assert ({stall, md_busy} === {s, b})
    else begin
      errors++;
      $error("FAIL %s: got stall=%b md_busy=%b, want stall=%b md_busy=%b", tag, stall, md_busy, s, b);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
`ifdef HAZ_MDU_EN
    D_is_md = 1'b0; D_is_mul = 1'b0; D_uses_md = 1'b0;
`endif
    set_d(1, 1, 2, 1, 1, 1, 3, 1);
    #2 chk("reset_state", 0, 0, 0);
    step();
    reset = 1'b0;
    #1;
    // add $3,$1,$2 with nothing in flight
    chk("add_clean", 0, 0, 0);
    step();                              // E=$3(1)
    set_d(1, 1, 0, 1, 4, 1, 5, 2);       // lw $5
    chk("lw_issue", 0, 0, 0);
    step();                              // E=$5(2) M=$3(0)
    set_d(1, 5, 0, 1, 1, 1, 6, 1);       // add $6,$5,$0
    chk("lw_use_stall", 1, 0, 0);
    step();                              // E=bub M=$5(1) W=$3(0)
    chk("lw_use_go", 0, 0, 0);
    step();                              // E=$6(1) M=bub W=$5(0)
    set_d(1, 5, 6, 1, 1, 0, 0, 0);
    chk("lw_fwd_w", 0, 3, 0);
    step();
    set_d(1, 0, 0, 1, 4, 1, 4, 1);       // ori $4
    chk("ori_issue", 0, 0, 0);
    step();                              // E=$4(1)
    set_d(1, 4, 4, 0, 0, 0, 0, 0);       // beq $4,$4
    chk("beq_stall", 1, 0, 0);
    step();                              // M=$4(0)
    chk("beq_fwd_m", 0, 2, 2);
    step();                              // W=$4(0)
    set_d(1, 4, 0, 0, 4, 0, 0, 0);
    chk("repeat_fwd_w", 0, 3, 0);
    step();
    set_d(1, 0, 0, 1, 4, 1, 7, 1);       // ori $7
    step();
    set_d(1, 0, 0, 1, 4, 1, 7, 2);       // lw $7
    step();                              // E=lw$7(2) M=ori$7(0)
    set_d(1, 7, 7, 1, 1, 0, 0, 0);
    chk("shadow_stall", 1, 0, 0);
    step();                              // M=lw$7(1) W=ori$7(0)
    chk("shadow_go", 0, 0, 0);
    step();                              // W=lw$7(0)
    chk("shadow_fwd_w", 0, 3, 3);
    step();
    set_d(1, 0, 0, 1, 4, 1, 0, 1);       // ori $0
    step();
    set_d(1, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_reg", 0, 0, 0);
    step();
    set_d(1, 0, 0, 1, 4, 1, 9, 5);       // writer with Tnew beyond pipe depth
    step();                              // E=$9(5)
    set_d(1, 9, 0, 4, 4, 0, 0, 0);
    chk("big_tnew_e", 1, 0, 0);
    set_d(0, 9, 0, 4, 4, 0, 0, 0);
    chk("invalid_no_stall", 0, 0, 0);
    step();                              // M=$9(4)
    step();                              // W=$9(3)
    set_d(1, 9, 9, 2, 3, 0, 0, 0);
    chk("big_tnew_w", 1, 0, 0);
    set_d(0, 9, 9, 2, 3, 0, 0, 0);
    step();                              // drained out
    set_d(1, 9, 9, 0, 0, 0, 0, 0);
    chk("big_tnew_gone", 0, 0, 0);
    step();
    set_d(1, 0, 0, 1, 4, 1, 5, 2);       // lw $5
    step();
    set_d(1, 5, 5, 1, 1, 0, 0, 0);
    chk("pre_reset_stall", 1, 0, 0);
    #2 reset = 1'b1;
    #1 chk("async_reset", 0, 0, 0);
    #1 reset = 1'b0;
    step();
    set_d(1, 5, 5, 0, 0, 0, 0, 0);
    chk("post_reset", 0, 0, 0);
`ifdef HAZ_MDU_EN
    step();
    set_d(1, 0, 0, 4, 4, 0, 0, 0);
    D_is_md = 1'b1; D_is_mul = 1'b1;     // mult
    #1 chk_md("mult_issue", 0, 0);
    step();
    D_is_md = 1'b0; D_uses_md = 1'b1;    // mfhi
    #1;
    for (int i = 0; i < 5; i++) begin
      chk_md("mult_busy", 1, 1);
      step();
    end
    chk_md("mult_done", 0, 0);
    step();
    D_uses_md = 1'b0; D_is_md = 1'b1; D_is_mul = 1'b0;  // div
    #1;
    step();
    D_is_md = 1'b0;
    D_valid = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk_md("div_busy", 0, 1);
      if (i == 3) begin
        D_valid = 1'b1; D_is_md = 1'b1; D_is_mul = 1'b1;
        #1 chk_md("md_during_div", 1, 1);
        D_valid = 1'b0; D_is_md = 1'b0;
        #1;
      end
      step();
    end
    chk_md("div_done", 0, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
